counter_job_sched: RTL
======================

// Module: counter_job_sched
// PURPOSE
//  Round-robin scheduler that shares one 4-bit accumulating counter between NREQ requesters.
//  The counter is count_out <= count_out + count_in per clk, with sync clear.
//  Each requester posts a job (step value, cycle count). The block grants one job at a time,
//  clears the counter, drives the step for the requested cycles and returns the final count.
//  It sits between the requesting agents and the counter instance; it owns its clear and step inputs.
// PARAMETERS
//  NREQ  4  number of requesters (>=2); IDW = $clog2(NREQ) is a derived localparam
//  W     4  counter width (step and result width)
//  CW    8  width of the per-job cycle count
// PORTS
//  clk        in   1        clock, all logic on rising edge
//  reset      in   1        synchronous, active-high reset
//  req        in   NREQ     per-requester job request (level)
//  req_step   in   NREQ*W   packed step values, slice i = req_step[i*W +: W]
//  req_cycles in   NREQ*CW  packed cycle counts, slice i = req_cycles[i*CW +: CW]
//  gnt        out  NREQ     one-hot grant, held for the whole job
//  busy       out  1        high whenever state != IDLE
//  done       out  1        one-cycle pulse, job complete
//  done_id    out  IDW      index of the finished requester, valid with done
//  result     out  W        final counter value, valid with done, held until next done
//  ctr_reset  out  1        to counter reset
//  ctr_step   out  W        to counter count_in
//  ctr_value  in   W        from counter count_out
// BEHAVIOUR
//  - Reset: state=IDLE, gnt=0, done=0, done_id=0, result=0, ctr_step=0, rr pointer=NREQ-1.
//    ctr_reset = reset | (state==CLEAR), so the counter also clears during reset.
//  - States: IDLE -> CLEAR -> RUN -> DONE -> IDLE.
//  - IDLE: if |req, pick the first set bit scanning from ptr+1 upward, modulo NREQ.
//    Latch that requester's step and cycles, set gnt one-hot, set ptr to the winner, go CLEAR.
//    Otherwise stay in IDLE with ctr_step=0.
//  - CLEAR (1 cycle): ctr_reset=1, ctr_step=0. Go to RUN if cycles!=0, else DONE.
//  - RUN: ctr_step=latched step for exactly `cycles` cycles, with a down-counter for remaining cycles.
//    After the last RUN cycle, go DONE.
//  - DONE (1 cycle): ctr_step=0. Register result<=ctr_value, done<=1, done_id<=winner.
//    gnt clears on the same edge, then state goes IDLE.
//  - Timing: req sampled in IDLE at edge E0. gnt is high from E0 until the edge after DONE.
//    done is high for 1 cycle, N+3 edges after E0 (N=cycles). N=0 gives done 3 edges after E0.
//  - Arithmetic: result = (step*N) mod 2^W; counter wrap is natural and is not flagged.
//  - req and slices are sampled only at grant; later changes in them are ignored.
//    A deasserted req of the granted requester does not abort the job.
//  - A requester holding req after done is re-arbitrated.
//    The rotating pointer makes any other pending requester win first.
//  - Reset mid-job: on the next edge go IDLE, gnt=0, no done for the aborted job, result=0.
//  - IDLE always lasts >=1 cycle between jobs, so there is no back-to-back grant without an IDLE cycle.
// TESTING
//  1 req[0]=1, step0=1, cycles0=5 -> gnt=0001; done 8 edges after E0; result=5; done_id=0.
//  2 req[1], step=3, cycles=6 (W=4) -> result=2 (18 mod 16); no wrap flag; gnt=0010 throughout.
//  3 req[2], cycles=0, step=7 -> ctr_step never 7; done 3 edges after E0; result=0.
//  4 After reset, req=1111 held -> grant order 0,1,2,3,0; each gnt one-hot; busy drops 1 cycle between jobs.
//  5 reset=1 during RUN of job (step=2, cycles=10) -> next cycle IDLE, gnt=0, ctr_reset=1, no done pulse.
//  6 req[0] held after its done with req[3] pending -> req[3] granted next, then req[0].
//    req/step changed mid-job -> result unaffected.

Source files
------------

// File: rtl/counter_job_sched.sv
// Round-robin job scheduler in front of a shared accumulating counter.
// Grants one requester at a time, clears the counter, drives its step for N cycles, returns the count.
module counter_job_sched #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int CW   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*W-1:0]    req_step,
  input  logic [NREQ*CW-1:0]   req_cycles,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [W-1:0]         result,
  output logic                 ctr_reset,
  output logic [W-1:0]         ctr_step,
  input  logic [W-1:0]         ctr_value
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic            r_done;
  logic [IDW-1:0]  r_doneId;
  logic [W-1:0]    r_result;
  logic [W-1:0]    r_ctrStep;
  logic [IDW-1:0]  r_ptr;
  logic [W-1:0]    r_step;
  logic [CW-1:0]   r_remain;

  logic            w_found;
  logic [IDW-1:0]  w_winner;
  logic [W-1:0]    w_winStep;
  logic [CW-1:0]   w_winCycles;
  int              w_idx;

  // Scan upward from the slot after the last winner so every pending requester gets a turn.
  always_comb begin
    w_found     = 1'b0;
    w_winner    = '0;
    w_winStep   = '0;
    w_winCycles = '0;
    w_idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req[w_idx]) begin
        w_found     = 1'b1;
        w_winner    = IDW'(w_idx);
        w_winStep   = req_step[w_idx*W +: W];
        w_winCycles = req_cycles[w_idx*CW +: CW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_done    <= 1'b0;
      r_doneId  <= '0;
      r_result  <= '0;
      r_ctrStep <= '0;
      r_ptr     <= IDW'(NREQ - 1);
      r_step    <= '0;
      r_remain  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ctrStep <= '0;
          if (w_found) begin
            r_step   <= w_winStep;
            r_remain <= w_winCycles;
            r_gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
            r_ptr    <= w_winner;
            r_state  <= CLEAR;
          end
        end
        CLEAR: begin
          if (r_remain != '0) begin
            r_ctrStep <= r_step;
            r_state   <= RUN;
          end else begin
            r_ctrStep <= '0;
            r_state   <= DONE;
          end
        end
        RUN: begin
          // The step is dropped on the edge that ends the last RUN cycle, so exactly N adds land.
          if (r_remain == CW'(1)) begin
            r_ctrStep <= '0;
            r_state   <= DONE;
          end else begin
            r_remain <= r_remain - CW'(1);
          end
        end
        DONE: begin
          r_ctrStep <= '0;
          r_result  <= ctr_value;
          r_done    <= 1'b1;
          r_doneId  <= r_ptr;
          r_gnt     <= '0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign done_id   = r_doneId;
  assign result    = r_result;
  assign ctr_step  = r_ctrStep;
  assign ctr_reset = reset | (r_state == CLEAR);

endmodule
